// File: rtl/mem_pkg.sv
// Shared types and default sizing for the data-memory responder.
package mem_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_e;
  localparam int DEFAULT_DEPTH   = 64;
  localparam int DEFAULT_LATENCY = 2;
endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 word storage: one synchronous write port, one asynchronous read port, no reset.
module dmem_array #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: accepts one request, answers with a one-cycle strobe
// LATENCY edges later, and flags misaligned or out-of-range addresses.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int       AW       = $clog2(DEPTH);
  localparam bit [2:0] LAT_LAST = 3'(LATENCY - 1);

  generate
    if (LATENCY < 1 || LATENCY > 7) begin : g_bad_latency
      $error("dmem_responder: LATENCY must be 1..7");
    end
    if (DEPTH < 4 || DEPTH > 1024 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("dmem_responder: DEPTH must be a power of two in 4..1024");
    end
  endgenerate

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  logic          accept, enter_resp;
  logic          cur_wr, cur_err;
  logic [31:0]   cur_addr, cur_wdata, rd_data;
  logic [AW-1:0] cur_idx;
  logic          we;

  assign accept = req_valid && (state_q == IDLE);

  // With LATENCY=1 RESP is entered on the accepting edge, so the latches are not yet loaded.
  assign cur_addr  = accept ? req_addr  : addr_q;
  assign cur_wdata = accept ? req_wdata : wdata_q;
  assign cur_wr    = accept ? req_write : wr_q;
  assign cur_idx   = cur_addr[AW+1:2];
  assign cur_err   = (cur_addr[1:0] != 2'b00) || (cur_addr[31:AW+2] != '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = BUSY;
            cnt_d   = 3'd1;
          end
        end
      end
      BUSY: begin
        if (cnt_q == LAT_LAST) begin
          state_d = RESP;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign enter_resp = (state_d == RESP) && (state_q != RESP);
  assign we         = enter_resp && cur_wr && !cur_err;

  always_comb begin
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = enter_resp;
    rsp_err_d   = enter_resp && cur_err;
    rsp_rdata_d = (enter_resp && !cur_wr && !cur_err) ? rd_data : 32'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      wr_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .we    (we),
    .waddr (cur_idx),
    .wdata (cur_wdata),
    .raddr (cur_idx),
    .rdata (rd_data)
  );

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2 instance checked by table and random traffic against a
// word-array model, plus a LATENCY=1 instance for back-to-back store/load.
module tb_dmem_responder;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_write;
  logic [31:0] req_addr, req_wdata;
  logic        v2, v1;
  logic        r2_ready, r2_valid, r2_err, r1_ready, r1_valid, r1_err;
  logic [31:0] r2_rdata, r1_rdata;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .req_valid(v2), .req_ready(r2_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(r2_valid), .rsp_rdata(r2_rdata),
    .rsp_err(r2_err));

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(v1), .req_ready(r1_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(r1_valid), .rsp_rdata(r1_rdata),
    .rsp_err(r1_err));

  int          sel = 2;
  logic        c_ready, c_valid, c_err;
  logic [31:0] c_rdata;
  always_comb begin
    c_ready = (sel == 1) ? r1_ready : r2_ready;
    c_valid = (sel == 1) ? r1_valid : r2_valid;
    c_err   = (sel == 1) ? r1_err   : r2_err;
    c_rdata = (sel == 1) ? r1_rdata : r2_rdata;
  end

  int checks = 0;
  int errors = 0;

  // Reference model for the LATENCY=2 instance: plain word array plus "ever written" flags.
  logic [31:0] mdl_mem   [DEPTH];
  bit          mdl_known [DEPTH];

  function automatic bit mdl_err(input logic [31:0] a);
    return (a % 4 != 0) || (a >= DEPTH * 4);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_valid(input bit v);
    if (sel == 1) v1 = v; else v2 = v;
  endtask

  // One request: wait for ready, accept, scramble inputs, measure latency, check the idle cycle after.
  task automatic do_req(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int exp_lat, output logic [31:0] rd, output logic er);
    int n;
    int lat;
    n = 0;
    @(negedge clk);
    while (!c_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_req", {31'd0, c_ready}, 32'd1);
    req_write = wr; req_addr = addr; req_wdata = wdata;
    set_valid(1'b1);
    @(posedge clk);
    #1;
    set_valid(1'b0);
    req_write = ~wr; req_addr = $urandom; req_wdata = $urandom;
    lat = 0; rd = '0; er = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (c_valid) begin
        lat = k; rd = c_rdata; er = c_err;
        break;
      end
    end
    chk("latency", lat, exp_lat);
    @(negedge clk);
    chk("idle_strobe_err", {30'd0, c_valid, c_err}, 32'd0);
    chk("idle_rdata", c_rdata, 32'd0);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] rd;
  logic        er;

  initial begin
    reset = 1'b1; v1 = 1'b0; v2 = 1'b0;
    req_write = 1'b0; req_addr = '0; req_wdata = '0;
    #1;
    chk("reset_outputs", {28'd0, r2_ready, r2_valid, r2_err, r1_ready}, 32'b1001);
    chk("reset_rdata", r2_rdata, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    tbl.push_back('{1'b1, 32'h10,       32'hDEADBEEF, 32'h0,        1'b0});
    tbl.push_back('{1'b0, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0});
    tbl.push_back('{1'b0, 32'h13,       32'h0,        32'h0,        1'b1});
    tbl.push_back('{1'b0, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0});
    tbl.push_back('{1'b1, 32'h0,        32'h11111111, 32'h0,        1'b0});
    tbl.push_back('{1'b1, 32'h100,      32'h22222222, 32'h0,        1'b1});
    tbl.push_back('{1'b0, 32'h0,        32'h0,        32'h11111111, 1'b0});
    tbl.push_back('{1'b1, 32'h8,        32'h0BADF00D, 32'h0,        1'b0});
    tbl.push_back('{1'b1, 32'hFC,       32'hCAFEF00D, 32'h0,        1'b0});
    tbl.push_back('{1'b0, 32'hFC,       32'h0,        32'hCAFEF00D, 1'b0});
    tbl.push_back('{1'b0, 32'h80000010, 32'h0,        32'h0,        1'b1});
    tbl.push_back('{1'b1, 32'h102,      32'h33333333, 32'h0,        1'b1});
    tbl.push_back('{1'b0, 32'h2,        32'h0,        32'h0,        1'b1});
    tbl.push_back('{1'b0, 32'h8,        32'h0,        32'h0BADF00D, 1'b0});

    sel = 2;
    for (int i = 0; i < tbl.size(); i++) begin
      do_req(tbl[i].wr, tbl[i].addr, tbl[i].wdata, 2, rd, er);
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rdata);
      chk($sformatf("tbl%0d_err", i), {31'd0, er}, {31'd0, tbl[i].exp_err});
      if (tbl[i].wr && !mdl_err(tbl[i].addr)) begin
        mdl_mem[tbl[i].addr / 4]   = tbl[i].wdata;
        mdl_known[tbl[i].addr / 4] = 1'b1;
      end
    end

    // req_valid held high across three loads: accepts must be LATENCY+1 = 3 cycles apart.
    begin
      logic [31:0] addrs [3];
      int          acc[$];
      logic [31:0] rq[$];
      int          ai;
      bit          acc_now;
      addrs[0] = 32'h10; addrs[1] = 32'h0; addrs[2] = 32'hFC;
      ai = 0;
      @(posedge clk); #1;
      req_write = 1'b0; req_addr = addrs[0]; v2 = 1'b1;
      for (int cyc = 0; cyc < 60; cyc++) begin
        @(negedge clk);
        if (c_valid) rq.push_back(c_rdata);
        acc_now = c_ready && v2;
        if (acc_now) acc.push_back(cyc);
        @(posedge clk); #1;
        if (acc_now) begin
          ai++;
          chk("ready_low_after_accept", {31'd0, c_ready}, 32'd0);
          if (ai < 3) req_addr = addrs[ai]; else v2 = 1'b0;
        end
        if (ai == 3 && rq.size() == 3) break;
      end
      v2 = 1'b0;
      chk("thru_accepts", acc.size(), 3);
      chk("thru_responses", rq.size(), 3);
      if (acc.size() == 3) begin
        chk("thru_gap1", acc[1] - acc[0], 3);
        chk("thru_gap2", acc[2] - acc[1], 3);
      end
      for (int i = 0; i < rq.size() && i < 3; i++)
        chk($sformatf("thru_rdata%0d", i), rq[i], mdl_mem[addrs[i] / 4]);
    end

    // Reset while a store is in BUSY: the store must vanish.
    begin
      int strobes;
      @(negedge clk);
      chk("rst_seq_ready", {31'd0, c_ready}, 32'd1);
      req_write = 1'b1; req_addr = 32'h8; req_wdata = 32'h12345678; v2 = 1'b1;
      @(posedge clk); #1;
      v2 = 1'b0;
      chk("busy_ready_low", {31'd0, c_ready}, 32'd0);
      #2;
      reset = 1'b1;
      #1;
      chk("async_reset_ready", {30'd0, c_ready, c_valid}, 32'b10);
      strobes = 0;
      repeat (2) begin
        @(negedge clk);
        if (c_valid) strobes++;
      end
      reset = 1'b0;
      repeat (4) begin
        @(negedge clk);
        if (c_valid) strobes++;
      end
      chk("reset_no_strobe", strobes, 0);
      do_req(1'b0, 32'h8, 32'h0, 2, rd, er);
      chk("reset_store_dropped", rd, 32'h0BADF00D);
    end

    // Random traffic against the model.
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a, d;
      bit          w, e;
      int          kind;
      kind = $urandom_range(0, 9);
      w    = $urandom_range(0, 1);
      d    = $urandom;
      if (kind <= 6)      a = $urandom_range(0, DEPTH - 1) * 4;
      else if (kind == 7) a = $urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3);
      else if (kind == 8) a = DEPTH * 4 + $urandom_range(0, 255) * 4;
      else                a = $urandom;
      e = mdl_err(a);
      do_req(w, a, d, 2, rd, er);
      chk($sformatf("rnd%0d_err a=%h", i, a), {31'd0, er}, {31'd0, e});
      if (e || w)                  chk($sformatf("rnd%0d_zero", i), rd, 32'd0);
      else if (mdl_known[a / 4])   chk($sformatf("rnd%0d_rdata a=%h", i, a), rd, mdl_mem[a / 4]);
      if (w && !e) begin
        mdl_mem[a / 4]   = d;
        mdl_known[a / 4] = 1'b1;
      end
    end

    // LATENCY=1 instance: store then load back-to-back.
    sel = 1;
    do_req(1'b1, 32'h4, 32'h1, 1, rd, er);
    chk("l1_store_rdata", rd, 32'd0);
    chk("l1_store_err", {31'd0, er}, 32'd0);
    do_req(1'b0, 32'h4, 32'h0, 1, rd, er);
    chk("l1_load_rdata", rd, 32'h00000001);
    chk("l1_load_err", {31'd0, er}, 32'd0);
    do_req(1'b0, 32'h5, 32'h0, 1, rd, er);
    chk("l1_misaligned_err", {31'd0, er}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 64: number of 32-bit words stored (power of two, 4..1024).
REQ-002 SHALL have parameter LATENCY, default 2: rising edges from request accept to response (legal 1..7; other values SHALL fail elaboration).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request this cycle.
REQ-007 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address (aluout of the datapath).
REQ-009 SHALL have port req_wdata  input  32  store data (writedata of the datapath).
REQ-010 SHALL have port rsp_valid  output  1  one-cycle response strobe.
REQ-011 SHALL have port rsp_rdata  output  32  load data (readdata of the datapath).
REQ-012 SHALL have port rsp_err  output  1  request was misaligned or out of range.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, RESP; req_ready = 1 only in IDLE.
REQ-014 Accept SHALL occur on a rising edge with req_valid=1 and req_ready=1; addr, wdata and write are latched at that edge, and later input changes are ignored.
REQ-015 rsp_valid SHALL be high for exactly one cycle, beginning LATENCY rising edges after the accepting edge; state passes through BUSY (counter, 3 bits) only when LATENCY>1.
REQ-016 RESP SHALL return to IDLE on the next edge unconditionally; the response has no backpressure, and peak throughput is one request per LATENCY+1 cycles.
REQ-017 Word index SHALL be req_addr[log2(DEPTH)+1:2]; error = (addr[1:0]!=0) or (addr[31:log2(DEPTH)+2]!=0).
REQ-018 For an error request, rsp_err=1 and rsp_rdata=0, with no storage update.
REQ-019 A valid store SHALL commit on the edge entering RESP; rsp_rdata=0 for stores.
REQ-020 A valid load SHALL present mem[index] in the RESP cycle, including a store committed by the immediately preceding request.
REQ-021 rsp_rdata and rsp_err SHALL be 0 whenever rsp_valid=0.
REQ-022 req_valid in BUSY/RESP SHALL be ignored; the initiator holds it until accept.

Reset
REQ-023 Reset SHALL force IDLE, counter=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, req_ready=1 immediately, independent of clk.
REQ-024 Reset in BUSY SHALL discard the pending request; an uncommitted store SHALL never reach storage.
REQ-025 Storage contents SHALL NOT be reset; a read before any write returns undefined data.

Structure
REQ-026 Package mem_pkg SHALL hold the state enum (IDLE/BUSY/RESP) and the default DEPTH/LATENCY constants.
REQ-027 Storage SHALL be one sub-module, dmem_array (single write port, single async read port, DEPTH x 32).
REQ-028 FSM, counter, address check and latches SHALL reside in dmem_responder.

Verification
REQ-029 Store 0xDEADBEEF to 0x10, then load 0x10 (LATENCY=2) -> each rsp_valid occurs 2 edges after accept; load rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-030 Load 0x13 -> rsp_err=1, rsp_rdata=0; storage word 4 is unchanged on a later read.
REQ-031 Store to 0x100 with DEPTH=64 -> rsp_err=1; word 0 is unchanged, so no wrap-around write occurs.
REQ-032 req_valid held high continuously with 3 loads -> accepts spaced exactly LATENCY+1 cycles apart; req_ready=0 in BUSY/RESP.
REQ-033 Store 0x12345678 to 0x8, with reset asserted mid-BUSY -> rsp_valid never asserts, req_ready=1 asynchronously, and a later load of 0x8 returns the prior value.
REQ-034 LATENCY=1, store 0x1 at 0x4 then load 0x4 back-to-back -> response 1 edge after each accept; load returns 0x00000001.
